// File: rtl/sd_ctrl_arb_if.sv
// Request/engine bus between the SD controller arbiter and its client blocks.
// The slave modport is the arbiter's view; master is the requesters/engines side.
interface sd_ctrl_arb_if #(
  parameter int ADDR_W = 32
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;

  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              wr_busy;
  logic              wr_cs_n;
  logic              wr_mosi;

  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_busy;
  logic              rd_cs_n;
  logic              rd_mosi;

  modport slave (
    input  wr_req, wr_addr, rd_req, rd_addr,
    output wr_ack, rd_ack,
    output wr_start, wr_addr_o, rd_start, rd_addr_o,
    input  wr_busy, wr_cs_n, wr_mosi,
    input  rd_busy, rd_cs_n, rd_mosi
  );

  modport master (
    output wr_req, wr_addr, rd_req, rd_addr,
    input  wr_ack, rd_ack,
    input  wr_start, wr_addr_o, rd_start, rd_addr_o,
    output wr_busy, wr_cs_n, wr_mosi,
    output rd_busy, rd_cs_n, rd_mosi
  );
endinterface

// File: rtl/sd_ctrl_arb.sv
// SD-over-SPI controller top: waits for card init, then grants the single SPI
// lane to the write or read engine one whole transaction at a time, with a
// busy handshake and timeout guard on every grant.
module sd_ctrl_arb #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000,
  parameter logic [7:0]  BUSY_WAIT   = 8'd16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_end,
  input  logic         init_cs_n,
  input  logic         init_mosi,
  sd_ctrl_arb_if.slave bus,
  output logic         sd_cs_n,
  output logic         sd_mosi,
  output logic         init_done,
  output logic         ctrl_busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_GRANT,
    WR_WAIT,
    RD_GRANT,
    RD_WAIT
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        last_wr;
  logic [31:0] wait_cnt;
  logic        seen_busy;
  logic        eng_busy;
  logic        wait_done;
  logic        wait_abort;

  // Busy of whichever engine currently owns the lane; only meaningful in the wait states.
  assign eng_busy   = (state == WR_WAIT) ? bus.wr_busy : bus.rd_busy;
  assign wait_done  = seen_busy && !eng_busy;
  assign wait_abort = (!seen_busy && (wait_cnt == 32'(BUSY_WAIT))) ||
                      (wait_cnt == TIMEOUT_CYC);

  // State register, back to INIT on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= next_state;
  end

  // Next state: round-robin arbitration in IDLE, completion or abort in the wait states.
  always_comb begin
    next_state = state;
    case (state)
      INIT: begin
        if (init_end) next_state = IDLE;
      end
      IDLE: begin
        if (bus.wr_req && bus.rd_req) next_state = last_wr ? RD_GRANT : WR_GRANT;
        else if (bus.wr_req)          next_state = WR_GRANT;
        else if (bus.rd_req)          next_state = RD_GRANT;
      end
      WR_GRANT: next_state = WR_WAIT;
      RD_GRANT: next_state = RD_WAIT;
      WR_WAIT, RD_WAIT: begin
        if (wait_done || wait_abort) next_state = IDLE;
      end
      default: next_state = INIT;
    endcase
  end

  // Grant bookkeeping, address latches, saturating timeout counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done     <= 1'b0;
      timeout_err   <= 1'b0;
      last_wr       <= 1'b0;
      wait_cnt      <= '0;
      seen_busy     <= 1'b0;
      bus.wr_addr_o <= '0;
      bus.rd_addr_o <= '0;
    end else begin
      case (state)
        INIT: begin
          if (init_end) init_done <= 1'b1;
        end
        WR_GRANT: begin
          bus.wr_addr_o <= bus.wr_addr;
          last_wr       <= 1'b1;
          timeout_err   <= 1'b0;
          wait_cnt      <= '0;
          seen_busy     <= 1'b0;
        end
        RD_GRANT: begin
          bus.rd_addr_o <= bus.rd_addr;
          last_wr       <= 1'b0;
          timeout_err   <= 1'b0;
          wait_cnt      <= '0;
          seen_busy     <= 1'b0;
        end
        WR_WAIT, RD_WAIT: begin
          if (wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
          if (eng_busy) seen_busy <= 1'b1;
          if (wait_abort && !wait_done) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ack   = (state == WR_GRANT);
  assign bus.wr_start = (state == WR_GRANT);
  assign bus.rd_ack   = (state == RD_GRANT);
  assign bus.rd_start = (state == RD_GRANT);
  assign ctrl_busy    = (state != IDLE);

  // SPI lane mux, decoded from the registered state so ownership never glitches mid-grant.
  always_comb begin
    sd_cs_n = 1'b1;
    sd_mosi = 1'b1;
    case (state)
      INIT: begin
        sd_cs_n = init_cs_n;
        sd_mosi = init_mosi;
      end
      WR_GRANT, WR_WAIT: begin
        sd_cs_n = bus.wr_cs_n;
        sd_mosi = bus.wr_mosi;
      end
      RD_GRANT, RD_WAIT: begin
        sd_cs_n = bus.rd_cs_n;
        sd_mosi = bus.rd_mosi;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_ctrl_arb.sv
// Directed testbench for sd_ctrl_arb: init hold-off, single write, round-robin
// contention, both abort paths, the done-beats-abort boundary and async reset.
module tb_sd_ctrl_arb;

  logic clk = 1'b0;
  logic rst_n;
  logic init_end;
  logic init_cs_n;
  logic init_mosi;
  logic sd_cs_n;
  logic sd_mosi;
  logic init_done;
  logic ctrl_busy;
  logic timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  sd_ctrl_arb_if #(.ADDR_W(32)) bus ();

  sd_ctrl_arb #(
    .ADDR_W     (32),
    .TIMEOUT_CYC(32'd200),
    .BUSY_WAIT  (8'd16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_end   (init_end),
    .init_cs_n  (init_cs_n),
    .init_mosi  (init_mosi),
    .bus        (bus.slave),
    .sd_cs_n    (sd_cs_n),
    .sd_mosi    (sd_mosi),
    .init_done  (init_done),
    .ctrl_busy  (ctrl_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_defaults();
    init_end     = 1'b0;
    init_cs_n    = 1'b1;
    init_mosi    = 1'b1;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_busy  = 1'b0;
    bus.wr_cs_n  = 1'b0;
    bus.wr_mosi  = 1'b0;
    bus.rd_busy  = 1'b0;
    bus.rd_cs_n  = 1'b0;
    bus.rd_mosi  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_defaults();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.wr_ack, bus.rd_ack, bus.wr_start, bus.rd_start} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000",
               {bus.wr_ack, bus.rd_ack, bus.wr_start, bus.rd_start});
    end
    tests_run++;
    if ({bus.wr_addr_o, bus.rd_addr_o} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr: got %h %h expected 0 0", bus.wr_addr_o, bus.rd_addr_o);
    end
    tests_run++;
    if ({init_done, timeout_err, ctrl_busy} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got %b expected 001", {init_done, timeout_err, ctrl_busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init_hold();
    logic ack_seen;
    ack_seen    = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'h0000_1234;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wr_ack) ack_seen = 1'b1;
      init_cs_n = i[0];
      init_mosi = ~i[1];
      #1;
      tests_run++;
      if ({sd_cs_n, sd_mosi} !== {init_cs_n, init_mosi}) begin
        tests_failed++;
        $display("[TB] FAIL init_mux[%0d]: got %b expected %b", i, {sd_cs_n, sd_mosi},
                 {init_cs_n, init_mosi});
      end
    end
    tests_run++;
    if (ack_seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL init_no_ack: got ack %b expected 0", ack_seen);
    end
    init_end = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({init_done, ctrl_busy, bus.wr_ack, sd_cs_n, sd_mosi} !== 5'b10011) begin
      tests_failed++;
      $display("[TB] FAIL init_to_idle: got %b expected 10011",
               {init_done, ctrl_busy, bus.wr_ack, sd_cs_n, sd_mosi});
    end
    init_end = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.wr_ack, bus.wr_start, bus.rd_ack, bus.rd_start} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL first_write_ack: got %b expected 1100",
               {bus.wr_ack, bus.wr_start, bus.rd_ack, bus.rd_start});
    end
    bus.wr_req  = 1'b0;
    bus.wr_busy = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    tests_run++;
    if ({bus.wr_ack, bus.wr_start, bus.wr_addr_o} !== {2'b00, 32'h0000_1234}) begin
      tests_failed++;
      $display("[TB] FAIL write_addr_latch: got %b %h expected 00 00001234",
               {bus.wr_ack, bus.wr_start}, bus.wr_addr_o);
    end
    for (int i = 0; i < 50; i++) begin
      if (i != 0) @(negedge clk);
      bus.wr_cs_n = (i % 7 == 0);
      bus.wr_mosi = i[0] ^ i[2];
      #1;
      tests_run++;
      if ({sd_cs_n, sd_mosi, ctrl_busy} !== {bus.wr_cs_n, bus.wr_mosi, 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL write_mux[%0d]: got %b expected %b", i, {sd_cs_n, sd_mosi, ctrl_busy},
                 {bus.wr_cs_n, bus.wr_mosi, 1'b1});
      end
    end
    bus.wr_busy = 1'b0;
    bus.wr_cs_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({ctrl_busy, sd_cs_n, sd_mosi, timeout_err, init_done} !== 5'b01101) begin
      tests_failed++;
      $display("[TB] FAIL write_done_idle: got %b expected 01101",
               {ctrl_busy, sd_cs_n, sd_mosi, timeout_err, init_done});
    end
  endtask

  task automatic test_contention();
    logic got;
    logic exp_wr;
    rst_n = 1'b0;
    drive_defaults();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'h0000_9ABC;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_5678;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    init_end = 1'b1;
    @(negedge clk);
    init_end = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_wr = (k % 2 == 0);
      got    = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus.wr_ack || bus.rd_ack) got = 1'b1;
      end
      tests_run++;
      if (got !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL contention_wait[%0d]: got no grant expected grant within 20 cycles", k);
      end else begin
        tests_run++;
        if ({bus.wr_ack, bus.wr_start, bus.rd_ack, bus.rd_start} !==
            {exp_wr, exp_wr, ~exp_wr, ~exp_wr}) begin
          tests_failed++;
          $display("[TB] FAIL contention_order[%0d]: got %b expected %b", k,
                   {bus.wr_ack, bus.wr_start, bus.rd_ack, bus.rd_start},
                   {exp_wr, exp_wr, ~exp_wr, ~exp_wr});
        end
      end
      if (exp_wr) bus.wr_busy = 1'b1;
      else        bus.rd_busy = 1'b1;
      repeat (3) @(negedge clk);
      bus.wr_busy = 1'b0;
      bus.rd_busy = 1'b0;
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.wr_addr_o, bus.rd_addr_o, ctrl_busy} !== {32'h0000_9ABC, 32'h0000_5678, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL contention_addr: got %h %h %b expected 00009abc 00005678 0",
               bus.wr_addr_o, bus.rd_addr_o, ctrl_busy);
    end
  endtask

  task automatic test_no_busy_abort();
    logic got;
    got         = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'hCAFE_0001;
    bus.rd_cs_n = 1'b0;
    bus.rd_mosi = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.rd_ack) got = 1'b1;
    end
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL nobusy_grant: got no rd_ack expected rd_ack");
    end
    bus.rd_req = 1'b0;
    repeat (17) @(negedge clk);
    tests_run++;
    if ({timeout_err, ctrl_busy, sd_cs_n} !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL nobusy_before_limit: got %b expected 010", {timeout_err, ctrl_busy, sd_cs_n});
    end
    @(negedge clk);
    tests_run++;
    if ({timeout_err, ctrl_busy, sd_cs_n, sd_mosi} !== 4'b1011) begin
      tests_failed++;
      $display("[TB] FAIL nobusy_abort: got %b expected 1011",
               {timeout_err, ctrl_busy, sd_cs_n, sd_mosi});
    end
    tests_run++;
    if (bus.rd_addr_o !== 32'hCAFE_0001) begin
      tests_failed++;
      $display("[TB] FAIL nobusy_addr: got %h expected cafe0001", bus.rd_addr_o);
    end
  endtask

  task automatic test_long_busy_abort();
    logic got;
    got         = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'h0BAD_F00D;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.wr_ack) got = 1'b1;
    end
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL longbusy_grant: got no wr_ack expected wr_ack");
    end
    bus.wr_req  = 1'b0;
    bus.wr_busy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL grant_clears_err: got %b expected 0", timeout_err);
    end
    repeat (200) @(negedge clk);
    tests_run++;
    if ({timeout_err, ctrl_busy} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL longbusy_before_limit: got %b expected 01", {timeout_err, ctrl_busy});
    end
    @(negedge clk);
    tests_run++;
    if ({timeout_err, ctrl_busy, sd_cs_n} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL longbusy_abort: got %b expected 101", {timeout_err, ctrl_busy, sd_cs_n});
    end
    bus.wr_busy = 1'b0;
  endtask

  task automatic test_busy_fall_at_limit();
    logic got;
    got         = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'h0000_00C8;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.wr_ack) got = 1'b1;
    end
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL edge_grant: got no wr_ack expected wr_ack");
    end
    bus.wr_req  = 1'b0;
    bus.wr_busy = 1'b1;
    repeat (201) @(negedge clk);
    bus.wr_busy = 1'b0;
    tests_run++;
    if ({timeout_err, ctrl_busy} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL edge_still_waiting: got %b expected 01", {timeout_err, ctrl_busy});
    end
    @(negedge clk);
    tests_run++;
    if ({timeout_err, ctrl_busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL edge_done_wins: got %b expected 00", {timeout_err, ctrl_busy});
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    logic ack_seen;
    got         = 1'b0;
    ack_seen    = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h1357_2468;
    bus.rd_cs_n = 1'b0;
    bus.rd_mosi = 1'b1;
    init_cs_n   = 1'b1;
    init_mosi   = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.rd_ack) got = 1'b1;
    end
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_grant: got no rd_ack expected rd_ack");
    end
    bus.rd_req  = 1'b0;
    bus.rd_busy = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    tests_run++;
    if ({sd_cs_n, sd_mosi, ctrl_busy} !== 3'b011) begin
      tests_failed++;
      $display("[TB] FAIL midrst_in_wait: got %b expected 011", {sd_cs_n, sd_mosi, ctrl_busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.rd_addr_o, bus.wr_addr_o} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_addr: got %h %h expected 0 0", bus.rd_addr_o, bus.wr_addr_o);
    end
    tests_run++;
    if ({init_done, timeout_err, ctrl_busy, bus.rd_ack, bus.rd_start, sd_cs_n, sd_mosi} !==
        7'b0010010) begin
      tests_failed++;
      $display("[TB] FAIL midrst_status: got %b expected 0010010",
               {init_done, timeout_err, ctrl_busy, bus.rd_ack, bus.rd_start, sd_cs_n, sd_mosi});
    end
    bus.rd_busy = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_ack || bus.rd_ack) ack_seen = 1'b1;
    end
    tests_run++;
    if ({ack_seen, init_done, ctrl_busy} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL midrst_hold: got %b expected 001", {ack_seen, init_done, ctrl_busy});
    end
    init_end = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.wr_ack) got = 1'b1;
    end
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_resume: got no wr_ack expected wr_ack after init_end");
    end
    bus.wr_req = 1'b0;
    init_end   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_hold();
    test_single_write();
    test_contention();
    test_no_busy_abort();
    test_long_busy_abort();
    test_busy_fall_at_limit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
